ser_frame_ctrl: RTL and testbench
=================================

# ser_frame_ctrl

Sequencer and round-robin arbiter for the parallel-to-serial shift register in the CPLD serial-output path. Several requesters offer WORD_W-bit status words. The block grants one at a time and drives the shift register's parallel-data and active-low load inputs. It then counts the WORD_W serial bit times and inserts an inter-frame gap. It also emits a frame-sync strobe aligned with bit 0 on the serial line and a per-frame completion pulse.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WORD_W, 8, frame width; must equal the shift register's TOTAL_BIT_COUNT
- GAP_CYCLES, 2, idle serclk cycles after the last bit (0..15)

- serclk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  1 = new grants allowed; an in-flight frame always completes
- req_valid  in  NUM_REQ  per-requester word available
- req_data  in  NUM_REQ*WORD_W  word i at [i*WORD_W +: WORD_W]
- req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready at a rising edge
- par_data_out  out  WORD_W  to the shift register's parallel data input
- par_load_out_n  out  1  to the shift register's load input, active low
- frame_sync  out  1  high while bit 0 of a frame is on the serial output
- cur_id  out  $clog2(NUM_REQ)  index of the requester owning the current frame
- busy  out  1  high in LOAD, SHIFT and GAP
- frame_done  out  1  one-cycle pulse on the last SHIFT cycle

## Operation
- States: IDLE, LOAD, SHIFT, GAP.
- **IDLE**
  - If enable and any req_valid: req_ready is asserted combinationally, one-hot, to the first valid requester at or after rr_ptr (wrapping).
  - At the edge: capture the granted word into hold_reg, latch cur_id, set rr_ptr = grant+1 mod NUM_REQ, go to LOAD.
  - Otherwise req_ready = 0.
- **LOAD** (1 cycle)
  - par_load_out_n = 0 and par_data_out = hold_reg.
  - Go to SHIFT with bit_cnt = 0.
- **SHIFT** (WORD_W cycles)
  - par_load_out_n = 1; bit_cnt increments each cycle.
  - frame_sync = 1 when bit_cnt == 0.
  - frame_done = 1 when bit_cnt == WORD_W-1; the next state is GAP, or IDLE if GAP_CYCLES == 0.
- **GAP**
  - gap_cnt counts GAP_CYCLES cycles, then the block returns to IDLE.
  - The shift register shifts in zeros, so the serial line is 0.
- req_ready is only ever nonzero in IDLE. A requester may drop valid before its grant without penalty.
- enable falling mid-frame has no effect until IDLE. In IDLE with enable = 0, no grant is issued.
- par_data_out holds hold_reg in every state after the first grant. Its value matters only while par_load_out_n = 0.
- Counter widths: bit_cnt $clog2(WORD_W+1), gap_cnt 4 bits. Counters never wrap: each is reset on entry to its state.

## Timing
- Reset values: state IDLE, rr_ptr 0, hold_reg 0, cur_id 0, req_ready 0, par_data_out 0, par_load_out_n 1, frame_sync 0, busy 0, frame_done 0.
- Reset asserted mid-frame aborts the frame immediately at the next edge. The shift register continues shifting out its residue, which is acceptable.
- Handshake at edge E:
  - LOAD during cycle E..E+1.
  - Shift register loaded at edge E+1.
  - Bit 0 on s_out and frame_sync high during E+1..E+2.
  - Bit k during cycle E+1+k.
- Frame period with continuous requests: 2 + WORD_W + GAP_CYCLES cycles. Defaults give 12.
- Simultaneous valids are resolved by round-robin: each of N always-valid requesters is served once per N frames.
- All outputs are registered except req_ready, which depends combinationally on req_valid, enable, rr_ptr and state.

## Structure
- Shared package ser_pkg holds:
  - the state enum (IDLE/LOAD/SHIFT/GAP)
  - the GAP counter width constant
  - a function rr_pick(valid, ptr) returning the one-hot grant
- One natural sub-module, rr_arbiter (parameter NUM_REQ), containing the grant logic and rr_ptr. The FSM, counters and hold_reg stay in the top level.
- The verification bench instantiates the existing shift register with TOTAL_BIT_COUNT = WORD_W, driven by par_data_out/par_load_out_n, and checks its s_out.

## Test plan
- Single frame: reset, then req_valid[2] = 1 with word 8'hA5. Required:
  - req_ready[2] pulses for 1 cycle; cur_id = 2.
  - s_out = 1,0,1,0,0,1,0,1 (LSB first) starting one cycle after LOAD; frame_sync on the first bit.
  - frame_done on the eighth bit; busy for 1+8+2 = 11 cycles.
- Round-robin: all 4 valid continuously, words 8'h01..8'h04 → grants in order 0,1,2,3,0; frames every 12 cycles.
- Priority wrap: rr_ptr = 3 (after a grant to 2), valid = 4'b0011 → requester 0 is granted, then requester 1.
- enable = 0 during SHIFT of a frame → the frame completes with frame_done; no req_ready until enable returns; the first grant comes the cycle enable = 1.
- Reset in the 4th SHIFT cycle → next cycle: state IDLE, busy 0, par_load_out_n 1, rr_ptr 0. A pending request is re-granted from requester 0.
- GAP_CYCLES = 0 build, two valid requesters → frame period 10 cycles; the LOAD cycle immediately follows the IDLE grant cycle after frame_done.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and helpers for the serial-frame sequencer and its arbiter.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  localparam int unsigned GAP_CNT_W = 4;
  localparam int unsigned MAX_REQ   = 8;

  // One-hot grant to the first valid requester at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    logic [2:0]         idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = 3'((32'(ptr) + i) % n);
      if (!found && (i < n) && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/ser_frame_ctrl_rr_arbiter.sv
// Round-robin grant logic; the pointer advances past each requester that is served.
module rr_arbiter
  import ser_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic               serclk,
  input  logic               reset,
  input  logic               grant_en,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0]    rr_ptr;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr), NUM_REQ);
    grant = grant_en ? pick[NUM_REQ-1:0] : '0;
  end

  always_comb begin
    grant_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  always_ff @(posedge serclk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/ser_frame_ctrl.sv
// Frame sequencer: grants one requester, loads the shift register, counts bit
// times and the inter-frame gap, and emits frame-sync / frame-done strobes.
module ser_frame_ctrl
  import ser_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned GAP_CYCLES = 2,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      serclk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [WORD_W-1:0]         par_data_out,
  output logic                      par_load_out_n,
  output logic                      frame_sync,
  output logic [ID_W-1:0]           cur_id,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int unsigned BC_W = $clog2(WORD_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [GAP_CNT_W-1:0] LAST_GAP =
    GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [BC_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic [GAP_CNT_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [WORD_W-1:0]      hold_reg;
  logic [WORD_W-1:0]      word_sel;
  logic [ID_W-1:0]        grant_id;
  logic                   grant_en;

  assign grant_en = enable && (state == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .serclk    (serclk),
    .reset     (reset),
    .grant_en  (grant_en),
    .req_valid (req_valid),
    .grant     (req_ready),
    .grant_id  (grant_id)
  );

  always_comb begin
    word_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) word_sel = req_data[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    unique case (state)
      IDLE: begin
        if (|req_ready) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt   = SHIFT;
        bit_cnt_nxt = '0;
      end
      SHIFT: begin
        bit_cnt_nxt = bit_cnt + BC_W'(1);
        if (bit_cnt == LAST_BIT) begin
          state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
          gap_cnt_nxt = '0;
        end
      end
      GAP: begin
        if (gap_cnt == LAST_GAP) state_nxt = IDLE;
        else                     gap_cnt_nxt = gap_cnt + GAP_CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next-state view so they line up with the state they describe.
  always_ff @(posedge serclk) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      gap_cnt        <= '0;
      hold_reg       <= '0;
      cur_id         <= '0;
      par_load_out_n <= 1'b1;
      frame_sync     <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_nxt;
      bit_cnt        <= bit_cnt_nxt;
      gap_cnt        <= gap_cnt_nxt;
      par_load_out_n <= (state_nxt != LOAD);
      frame_sync     <= (state_nxt == SHIFT) && (bit_cnt_nxt == '0);
      frame_done     <= (state_nxt == SHIFT) && (bit_cnt_nxt == LAST_BIT);
      busy           <= (state_nxt != IDLE);
      if (|req_ready) begin
        hold_reg <= word_sel;
        cur_id   <= grant_id;
      end
    end
  end

  assign par_data_out = hold_reg;

endmodule

// File: tb/tb_ser_frame_ctrl.sv
// Directed bench for ser_frame_ctrl with a behavioural LSB-first shift register on each instance.
module tb_ser_frame_ctrl;

  logic        serclk = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_ready;
  logic [7:0]  par_data_out;
  logic        par_load_out_n, frame_sync, busy, frame_done;
  logic [1:0]  cur_id;

  logic        enable_g = 1'b1;
  logic [3:0]  req_valid_g = '0;
  logic [31:0] req_data_g  = '0;
  logic [3:0]  req_ready_g;
  logic [7:0]  par_data_out_g;
  logic        par_load_out_n_g, frame_sync_g, busy_g, frame_done_g;
  logic [1:0]  cur_id_g;

  logic [7:0]  sr = '0, sr_g = '0;
  logic        s_out, s_out_g;

  int n_assert = 0, n_fail = 0, cyc = 0;
  int t_prev, busy_cnt, seen_done, g;
  logic [3:0] ored;
  logic [7:0] word;

  ser_frame_ctrl #(.NUM_REQ(4), .WORD_W(8), .GAP_CYCLES(2)) dut (
    .serclk(serclk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .par_data_out(par_data_out), .par_load_out_n(par_load_out_n),
    .frame_sync(frame_sync), .cur_id(cur_id), .busy(busy), .frame_done(frame_done)
  );

  ser_frame_ctrl #(.NUM_REQ(4), .WORD_W(8), .GAP_CYCLES(0)) dut_g (
    .serclk(serclk), .reset(reset), .enable(enable_g),
    .req_valid(req_valid_g), .req_data(req_data_g), .req_ready(req_ready_g),
    .par_data_out(par_data_out_g), .par_load_out_n(par_load_out_n_g),
    .frame_sync(frame_sync_g), .cur_id(cur_id_g), .busy(busy_g), .frame_done(frame_done_g)
  );

  always #5 serclk = ~serclk;

  always @(posedge serclk) begin
    sr   <= !par_load_out_n   ? par_data_out   : {1'b0, sr[7:1]};
    sr_g <= !par_load_out_n_g ? par_data_out_g : {1'b0, sr_g[7:1]};
  end
  assign s_out   = sr[0];
  assign s_out_g = sr_g[0];

  task automatic tick();
    @(posedge serclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_load_n", 32'(par_load_out_n), 32'd1);
    chk("rst_sync",   32'(frame_sync), 32'd0);
    chk("rst_done",   32'(frame_done), 32'd0);
    chk("rst_ready",  32'(req_ready), 32'd0);
    chk("rst_cur_id", 32'(cur_id), 32'd0);
    chk("rst_pdata",  32'(par_data_out), 32'd0);
    reset = 1'b0;

    // single frame from requester 2
    word = 8'hA5;
    req_data  = 32'h00A5_0000;
    req_valid = 4'b0100;
    #1;
    chk("sf_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    #1;
    chk("sf_ready_drop", 32'(req_ready), 32'h0);
    chk("sf_cur_id", 32'(cur_id), 32'd2);
    chk("sf_load_n", 32'(par_load_out_n), 32'd0);
    chk("sf_pdata",  32'(par_data_out), 32'hA5);
    busy_cnt = busy ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("sf_sout",  32'(s_out), 32'(word[k]));
      chk("sf_sync",  32'(frame_sync), 32'(k == 0));
      chk("sf_done",  32'(frame_done), 32'(k == 7));
      if (busy) busy_cnt++;
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("sf_gap_sout", 32'(s_out), 32'd0);
      if (busy) busy_cnt++;
    end
    tick();
    chk("sf_busy_cycles", 32'(busy_cnt), 32'd11);
    chk("sf_idle", 32'(busy), 32'd0);

    // priority wrap: pointer sits at 3
    req_data  = 32'h0000_2211;
    req_valid = 4'b0011;
    #1;
    chk("pw_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("pw_cur0", 32'(cur_id), 32'd0);
    ored = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      ored |= req_ready;
    end
    chk("pw_busy_ready", 32'(ored), 32'h0);
    tick();
    chk("pw_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("pw_cur1", 32'(cur_id), 32'd1);
    req_valid = '0;
    repeat (11) tick();
    chk("pw_idle", 32'(busy), 32'd0);

    // round-robin with all requesters valid
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_data  = 32'h0403_0201;
    req_valid = 4'hF;
    #1;
    t_prev = 0;
    for (int f = 0; f < 5; f++) begin
      g = 0;
      while (req_ready == 0 && g < 40) begin
        tick();
        g++;
      end
      chk("rr_ready", 32'(req_ready), 32'(1 << (f % 4)));
      if (f > 0) chk("rr_period", 32'(cyc - t_prev), 32'd12);
      t_prev = cyc;
      tick();
      chk("rr_cur",   32'(cur_id), 32'(f % 4));
      chk("rr_pdata", 32'(par_data_out), 32'(f % 4 + 1));
    end

    // enable dropped during SHIFT
    tick();
    enable = 1'b0;
    seen_done = 0;
    ored = '0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (frame_done) seen_done++;
      ored |= req_ready;
    end
    chk("en_done", 32'(seen_done), 32'd1);
    chk("en_no_grant", 32'(ored), 32'h0);
    chk("en_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    #1;
    chk("en_regrant", 32'(req_ready), 32'h2);
    tick();
    chk("en_cur", 32'(cur_id), 32'd1);

    // reset during the 4th SHIFT cycle
    tick(); tick(); tick(); tick();
    chk("rs_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rs_busy",   32'(busy), 32'd0);
    chk("rs_load_n", 32'(par_load_out_n), 32'd1);
    chk("rs_sync",   32'(frame_sync), 32'd0);
    chk("rs_cur",    32'(cur_id), 32'd0);
    chk("rs_ready",  32'(req_ready), 32'h1);
    tick();
    chk("rs_cur_g",  32'(cur_id), 32'd0);
    chk("rs_pdata",  32'(par_data_out), 32'h01);
    req_valid = '0;
    repeat (12) tick();

    // zero-gap build, two requesters
    req_data_g  = 32'h0000_C33C;
    req_valid_g = 4'b0011;
    #1;
    t_prev = 0;
    for (int f = 0; f < 3; f++) begin
      g = 0;
      while (req_ready_g == 0 && g < 40) begin
        tick();
        g++;
      end
      chk("g0_ready", 32'(req_ready_g), 32'(1 << (f % 2)));
      if (f > 0) chk("g0_period", 32'(cyc - t_prev), 32'd10);
      t_prev = cyc;
      word = (f % 2 == 0) ? 8'h3C : 8'hC3;
      tick();
      chk("g0_load_n", 32'(par_load_out_n_g), 32'd0);
      tick();
      chk("g0_sync", 32'(frame_sync_g), 32'd1);
      chk("g0_bit0", 32'(s_out_g), 32'(word[0]));
      repeat (7) tick();
      chk("g0_done", 32'(frame_done_g), 32'd1);
      chk("g0_bit7", 32'(s_out_g), 32'(word[7]));
      tick();
      chk("g0_idle", 32'(busy_g), 32'd0);
    end
    req_valid_g = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
